// File: rtl/triangle_scan_rasterizer.sv
// Triangle rasterizer: latches three vertices and a flat colour, clamps the bounding box to the screen and streams covered pixels row-major. Build option BACKFACE_CULL_EN drops clockwise (A<0) triangles.
// Latency: SETUP 1 cycle after i_start, first candidate 2 cycles after i_start; o_done at 3+box_w*box_h cycles (2 for degenerate/empty/culled).
// Backpressure: o_valid && !i_ready freezes the scan and every output; uncovered candidates cost one cycle with o_valid low.
module triangle_scan_rasterizer #(
    parameter int COORD_W  = 16,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int CHANNELS = 4,
    parameter int CHAN_W   = 8
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_start,
    input  logic signed [COORD_W-1:0]        i_v1x,
    input  logic signed [COORD_W-1:0]        i_v1y,
    input  logic signed [COORD_W-1:0]        i_v2x,
    input  logic signed [COORD_W-1:0]        i_v2y,
    input  logic signed [COORD_W-1:0]        i_v3x,
    input  logic signed [COORD_W-1:0]        i_v3y,
    input  logic [CHANNELS*CHAN_W-1:0]       i_colour,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic signed [COORD_W-1:0]        o_x,
    output logic signed [COORD_W-1:0]        o_y,
    output logic [CHANNELS*CHAN_W-1:0]       o_colour,
    output logic                             o_idle,
    output logic                             o_done
);

    // Edge values are products of two (COORD_W+1)-bit differences minus another
    // such product; 2*COORD_W+2 signed bits hold that exactly.
    localparam int EW = 2 * COORD_W + 2;
    localparam int DW = COORD_W + 1;
    localparam logic signed [COORD_W-1:0] X_HI = COORD_W'(SCREEN_W - 1);
    localparam logic signed [COORD_W-1:0] Y_HI = COORD_W'(SCREEN_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;

    // Latched triangle
    logic signed [COORD_W-1:0] v1x, v1y, v2x, v2y, v3x, v3y;

    // Clamped box limits needed while scanning (min_y only matters in SETUP)
    logic signed [COORD_W-1:0] min_x, max_x, max_y;

    // Normalised edges at the current candidate, at the row start, and steps
    logic signed [EW-1:0] e_cur [3];
    logic signed [EW-1:0] e_row [3];
    logic signed [EW-1:0] e_sx  [3];
    logic signed [EW-1:0] e_sy  [3];

    // Setup-cycle combinational results
    logic signed [EW-1:0]      s_area;
    logic signed [COORD_W-1:0] lo_x, hi_x, lo_y, hi_y;
    logic signed [COORD_W-1:0] s_min_x, s_max_x, s_min_y, s_max_y;
    logic                      s_empty, s_flip, s_cull, s_skip;
    logic signed [EW-1:0]      raw_e  [3];
    logic signed [EW-1:0]      raw_sx [3];
    logic signed [EW-1:0]      raw_sy [3];
    logic signed [EW-1:0]      s_e    [3];
    logic signed [EW-1:0]      s_sx   [3];
    logic signed [EW-1:0]      s_sy   [3];

    // Scan-step combinational results
    logic                      last_x, last_cand, advance;
    logic signed [COORD_W-1:0] n_x, n_y;
    logic signed [EW-1:0]      n_row [3];
    logic signed [EW-1:0]      n_e   [3];

    // Exact difference of two coordinates (one extra bit, never overflows)
    function automatic logic signed [DW-1:0] diff(input logic signed [COORD_W-1:0] a,
                                                  input logic signed [COORD_W-1:0] b);
        return {a[COORD_W-1], a} - {b[COORD_W-1], b};
    endfunction

    // Sign-extend a difference to the edge width
    function automatic logic signed [EW-1:0] wide(input logic signed [DW-1:0] d);
        return {{(EW - DW){d[DW-1]}}, d};
    endfunction

    // Edge of segment a->b evaluated at p, oriented so that the interior of a
    // triangle with positive doubled area is non-negative. This is the negated
    // textbook E12 form; the area below is the same function at the third vertex.
    function automatic logic signed [EW-1:0] edge_at(
        input logic signed [COORD_W-1:0] px, input logic signed [COORD_W-1:0] py,
        input logic signed [COORD_W-1:0] ax, input logic signed [COORD_W-1:0] ay,
        input logic signed [COORD_W-1:0] bx, input logic signed [COORD_W-1:0] by);
        return wide(diff(py, ay)) * wide(diff(bx, ax)) - wide(diff(px, ax)) * wide(diff(by, ay));
    endfunction

    function automatic logic signed [COORD_W-1:0] min3(input logic signed [COORD_W-1:0] a,
                                                       input logic signed [COORD_W-1:0] b,
                                                       input logic signed [COORD_W-1:0] c);
        logic signed [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        m = (c < m) ? c : m;
        return m;
    endfunction

    function automatic logic signed [COORD_W-1:0] max3(input logic signed [COORD_W-1:0] a,
                                                       input logic signed [COORD_W-1:0] b,
                                                       input logic signed [COORD_W-1:0] c);
        logic signed [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        m = (c > m) ? c : m;
        return m;
    endfunction

    // A candidate is drawn when no normalised edge is negative
    function automatic logic covered(input logic signed [EW-1:0] a,
                                     input logic signed [EW-1:0] b,
                                     input logic signed [EW-1:0] c);
        return !a[EW-1] && !b[EW-1] && !c[EW-1];
    endfunction

    // Setup math: area, clamped box, edges at the box corner and their steps
    always_comb begin
        s_area  = edge_at(v3x, v3y, v1x, v1y, v2x, v2y);

        lo_x    = min3(v1x, v2x, v3x);
        hi_x    = max3(v1x, v2x, v3x);
        lo_y    = min3(v1y, v2y, v3y);
        hi_y    = max3(v1y, v2y, v3y);
        s_min_x = lo_x[COORD_W-1] ? '0 : lo_x;
        s_max_x = (hi_x > X_HI) ? X_HI : hi_x;
        s_min_y = lo_y[COORD_W-1] ? '0 : lo_y;
        s_max_y = (hi_y > Y_HI) ? Y_HI : hi_y;
        // A box entirely off one side ends up with min above max after clamping
        s_empty = (s_min_x > s_max_x) || (s_min_y > s_max_y);

        raw_e[0]  = edge_at(s_min_x, s_min_y, v1x, v1y, v2x, v2y);
        raw_sx[0] = wide(diff(v1y, v2y));
        raw_sy[0] = wide(diff(v2x, v1x));
        raw_e[1]  = edge_at(s_min_x, s_min_y, v2x, v2y, v3x, v3y);
        raw_sx[1] = wide(diff(v2y, v3y));
        raw_sy[1] = wide(diff(v3x, v2x));
        raw_e[2]  = edge_at(s_min_x, s_min_y, v3x, v3y, v1x, v1y);
        raw_sx[2] = wide(diff(v3y, v1y));
        raw_sy[2] = wide(diff(v1x, v3x));

        // Clockwise (negative area) triangles are flipped so coverage stays ">= 0"
        s_flip = s_area[EW-1];
        for (int i = 0; i < 3; i++) begin
            s_e[i]  = s_flip ? -raw_e[i]  : raw_e[i];
            s_sx[i] = s_flip ? -raw_sx[i] : raw_sx[i];
            s_sy[i] = s_flip ? -raw_sy[i] : raw_sy[i];
        end

`ifdef BACKFACE_CULL_EN
        s_cull = s_flip;
`else
        s_cull = 1'b0;
`endif
        s_skip = (s_area == '0) || s_empty || s_cull;
    end

    // Next candidate: step right, or wrap to the next row from the saved row start
    always_comb begin
        advance   = !o_valid || i_ready;
        last_x    = (o_x == max_x);
        last_cand = last_x && (o_y == max_y);
        n_x       = last_x ? min_x : o_x + COORD_W'(1);
        n_y       = last_x ? o_y + COORD_W'(1) : o_y;
        for (int i = 0; i < 3; i++) begin
            n_row[i] = e_row[i] + e_sy[i];
            n_e[i]   = last_x ? n_row[i] : e_cur[i] + e_sx[i];
        end
    end

    // Control FSM and registered datapath/outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= IDLE;
            o_valid  <= 1'b0;
            o_done   <= 1'b0;
            o_idle   <= 1'b1;
            o_x      <= '0;
            o_y      <= '0;
            o_colour <= '0;
            v1x      <= '0;
            v1y      <= '0;
            v2x      <= '0;
            v2y      <= '0;
            v3x      <= '0;
            v3y      <= '0;
            min_x    <= '0;
            max_x    <= '0;
            max_y    <= '0;
            for (int i = 0; i < 3; i++) begin
                e_cur[i] <= '0;
                e_row[i] <= '0;
                e_sx[i]  <= '0;
                e_sy[i]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        v1x      <= i_v1x;
                        v1y      <= i_v1y;
                        v2x      <= i_v2x;
                        v2y      <= i_v2y;
                        v3x      <= i_v3x;
                        v3y      <= i_v3y;
                        o_colour <= i_colour;
                        o_idle   <= 1'b0;
                        state    <= SETUP;
                    end
                end

                SETUP: begin
                    if (s_skip) begin
                        // Nothing to draw: report completion straight away
                        o_done <= 1'b1;
                        state  <= DONE;
                    end else begin
                        min_x   <= s_min_x;
                        max_x   <= s_max_x;
                        max_y   <= s_max_y;
                        o_x     <= s_min_x;
                        o_y     <= s_min_y;
                        for (int i = 0; i < 3; i++) begin
                            e_cur[i] <= s_e[i];
                            e_row[i] <= s_e[i];
                            e_sx[i]  <= s_sx[i];
                            e_sy[i]  <= s_sy[i];
                        end
                        o_valid <= covered(s_e[0], s_e[1], s_e[2]);
                        state   <= SCAN;
                    end
                end

                SCAN: begin
                    if (advance) begin
                        if (last_cand) begin
                            o_valid <= 1'b0;
                            state   <= DONE;
                        end else begin
                            o_x <= n_x;
                            o_y <= n_y;
                            for (int i = 0; i < 3; i++) begin
                                e_cur[i] <= n_e[i];
                                if (last_x) begin
                                    e_row[i] <= n_row[i];
                                end
                            end
                            o_valid <= covered(n_e[0], n_e[1], n_e[2]);
                        end
                    end
                end

                DONE: begin
                    // After a scan, DONE spends one drain cycle before the pulse;
                    // the skip path enters with o_done already raised.
                    if (o_done) begin
                        o_done <= 1'b0;
                        o_idle <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        o_done <= 1'b1;
                    end
                end

                default: begin
                    o_valid <= 1'b0;
                    o_done  <= 1'b0;
                    o_idle  <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_scan_rasterizer.sv
// Bench for triangle_scan_rasterizer: directed cases plus random triangles and random i_ready.
// Expected pixels come from a geometric same-side test over the clamped box.
// Each cycle is observed 1ns after the rising edge; inputs are driven then too.
module tb_triangle_scan_rasterizer;

    localparam int CW = 16;
    localparam int SW = 640;
    localparam int SH = 480;
    localparam int CH = 4;
    localparam int CB = 8;

`ifdef BACKFACE_CULL_EN
    localparam int CCW_CNT   = 0;
    localparam int CCW_FIRST = -1;
`else
    localparam int CCW_CNT   = 15;
    localparam int CCW_FIRST = 2;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic signed [CW-1:0] v1x = '0, v1y = '0, v2x = '0, v2y = '0, v3x = '0, v3y = '0;
    logic [CH*CB-1:0]     colour = '0;
    logic                 valid;
    logic                 ready = 1'b0;
    logic signed [CW-1:0] px, py;
    logic [CH*CB-1:0]     pcol;
    logic                 idle, done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int x;
        int y;
    } pix_t;

    pix_t exp_q[$];

    triangle_scan_rasterizer #(
        .COORD_W(CW), .SCREEN_W(SW), .SCREEN_H(SH), .CHANNELS(CH), .CHAN_W(CB)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start),
        .i_v1x(v1x), .i_v1y(v1y), .i_v2x(v2x), .i_v2y(v2y), .i_v3x(v3x), .i_v3y(v3y),
        .i_colour(colour), .o_valid(valid), .i_ready(ready),
        .o_x(px), .o_y(py), .o_colour(pcol), .o_idle(idle), .o_done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, required %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: every pixel of the clamped box lying on the inner side of all three edges
    task automatic build_model(input int x1, input int y1, input int x2, input int y2,
                               input int x3, input int y3, output int drawn, output int box);
        longint a, w0, w1, w2, s;
        int bx0, bx1, by0, by1;
        logic culled;
        pix_t p;
        a   = longint'(x2 - x1) * (y3 - y1) - longint'(y2 - y1) * (x3 - x1);
        bx0 = (x1 < x2) ? x1 : x2;  bx0 = (x3 < bx0) ? x3 : bx0;  bx0 = (bx0 < 0) ? 0 : bx0;
        bx1 = (x1 > x2) ? x1 : x2;  bx1 = (x3 > bx1) ? x3 : bx1;  bx1 = (bx1 > SW - 1) ? SW - 1 : bx1;
        by0 = (y1 < y2) ? y1 : y2;  by0 = (y3 < by0) ? y3 : by0;  by0 = (by0 < 0) ? 0 : by0;
        by1 = (y1 > y2) ? y1 : y2;  by1 = (y3 > by1) ? y3 : by1;  by1 = (by1 > SH - 1) ? SH - 1 : by1;
`ifdef BACKFACE_CULL_EN
        culled = (a < 0);
`else
        culled = 1'b0;
`endif
        exp_q.delete();
        drawn = 0;
        box   = 0;
        if (a != 0 && bx0 <= bx1 && by0 <= by1 && !culled) begin
            drawn = 1;
            box   = (bx1 - bx0 + 1) * (by1 - by0 + 1);
            s     = (a > 0) ? 1 : -1;
            for (int y = by0; y <= by1; y++) begin
                for (int x = bx0; x <= bx1; x++) begin
                    w0 = longint'(x2 - x1) * (y - y1) - longint'(y2 - y1) * (x - x1);
                    w1 = longint'(x3 - x2) * (y - y2) - longint'(y3 - y2) * (x - x2);
                    w2 = longint'(x1 - x3) * (y - y3) - longint'(y1 - y3) * (x - x3);
                    if (w0 * s >= 0 && w1 * s >= 0 && w2 * s >= 0) begin
                        p.x = x;
                        p.y = y;
                        exp_q.push_back(p);
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // mode: 0 ready always, 1 ready toggles, 2 ready random
    task automatic run_tri(input string name, input int x1, input int y1, input int x2, input int y2,
                           input int x3, input int y3, input logic [CH*CB-1:0] col,
                           input int mode, input int exp_cnt, input int exp_first);
        int drawn, box, n_model, c, stalls, accepted, first_valid, budget, hx, hy;
        logic held, done_seen, r;
        pix_t p;
        build_model(x1, y1, x2, y2, x3, y3, drawn, box);
        n_model = exp_q.size();
        chk({name, "_idle_pre"}, idle, 1);
        v1x = CW'(x1); v1y = CW'(y1); v2x = CW'(x2); v2y = CW'(y2); v3x = CW'(x3); v3y = CW'(y3);
        colour = col;
        start  = 1'b1;
        ready  = 1'b1;
        tick();
        start = 1'b0;
        // Scramble inputs so the DUT has to rely on what it latched
        v1x = CW'($urandom); v1y = CW'($urandom); v2x = CW'($urandom);
        v2y = CW'($urandom); v3x = CW'($urandom); v3y = CW'($urandom);
        colour = $urandom;
        c = 1; stalls = 0; accepted = 0; first_valid = -1; held = 1'b0; done_seen = 1'b0;
        hx = 0; hy = 0;
        budget = 200 + 8 * box;
        while (!done_seen && c < budget) begin
            if (held) begin
                chk({name, "_stall_valid"}, valid, 1);
                chk({name, "_stall_x"}, px, hx);
                chk({name, "_stall_y"}, py, hy);
            end
            if (c < 2) chk({name, "_setup_valid"}, valid, 0);
            if (done) begin
                done_seen = 1'b1;
                chk({name, "_done_cycle"}, c, drawn ? 3 + box + stalls : 2);
                chk({name, "_valid_at_done"}, valid, 0);
            end else begin
                chk({name, "_busy_idle"}, idle, 0);
            end
            if (valid && first_valid < 0) first_valid = c;
            case (mode)
                0:       r = 1'b1;
                1:       r = (c % 2 == 0);
                default: r = ($urandom_range(0, 3) != 0);
            endcase
            ready = r;
            held  = 1'b0;
            if (valid && !done) begin
                if (r) begin
                    if (exp_q.size() == 0) begin
                        chk({name, "_extra_pixel"}, accepted + 1, n_model);
                    end else begin
                        p = exp_q.pop_front();
                        chk({name, "_x"}, px, p.x);
                        chk({name, "_y"}, py, p.y);
                        chk({name, "_colour"}, pcol, col);
                    end
                    accepted++;
                end else begin
                    stalls++;
                    held = 1'b1;
                    hx = px;
                    hy = py;
                end
            end
            if (!done_seen) begin
                tick();
                c++;
            end
        end
        chk({name, "_done_seen"}, done_seen, 1);
        chk({name, "_pixel_count"}, accepted, n_model);
        if (exp_cnt >= 0) chk({name, "_plan_count"}, accepted, exp_cnt);
        if (exp_first >= 0) chk({name, "_first_valid"}, first_valid, exp_first);
        if (done_seen) begin
            tick();
            chk({name, "_idle_after"}, idle, 1);
            chk({name, "_done_pulse"}, done, 0);
        end else begin
            do_reset();
        end
    endtask

    // Reset while the third pixel of the reference triangle is stalled
    task automatic reset_mid_scan();
        int acc;
        logic found;
        v1x = 0; v1y = 0; v2x = 4; v2y = 0; v3x = 0; v3y = 4;
        colour = 32'h12345678;
        start = 1'b1;
        ready = 1'b1;
        tick();
        start = 1'b0;
        acc = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (valid) begin
                if (acc == 2) found = 1'b1;
                else acc++;
            end
            if (!found) tick();
        end
        chk("rst_third_seen", found, 1);
        ready = 1'b0;
        tick();
        chk("rst_stalled_valid", valid, 1);
        chk("rst_stalled_x", px, 2);
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_idle", idle, 1);
        chk("rst_done", done, 0);
        chk("rst_x", px, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_done", done, 0);
            chk("rst_idle_hold", idle, 1);
        end
    endtask

    initial begin
        int x1, y1, x2, y2, x3, y3, bx, by, region;
        #1 rst = 1'b1;
        tick();
        tick();
        chk("reset_valid", valid, 0);
        chk("reset_done", done, 0);
        chk("reset_idle", idle, 1);
        chk("reset_x", px, 0);
        chk("reset_y", py, 0);
        chk("reset_colour", pcol, 0);
        rst = 1'b0;
        tick();

        run_tri("ccw", 0, 0, 4, 0, 0, 4, 32'hFF0000FF, 0, 15, 2);
        run_tri("ccw_toggle", 0, 0, 4, 0, 0, 4, 32'hFF0000FF, 1, 15, 2);
        run_tri("cw", 0, 0, 0, 4, 4, 0, 32'h00FF00FF, 0, CCW_CNT, CCW_FIRST);
        run_tri("collinear", 1, 1, 3, 3, 5, 5, 32'hAABBCCDD, 0, 0, -1);
        run_tri("offscreen", -20, -20, -10, -20, -20, -10, 32'h01020304, 0, 0, -1);
        run_tri("corner", 630, 470, 700, 470, 630, 520, 32'hCAFEF00D, 0, 100, 2);
        reset_mid_scan();
        run_tri("after_rst", 0, 0, 4, 0, 0, 4, 32'hFF0000FF, 0, 15, 2);

        for (int t = 0; t < 24; t++) begin
            region = $urandom_range(0, 2);
            case (region)
                0:       begin bx = -6;  by = -6;  end
                1:       begin bx = 626; by = 466; end
                default: begin bx = 620; by = -5;  end
            endcase
            x1 = bx + int'($urandom_range(0, 24)); y1 = by + int'($urandom_range(0, 24));
            x2 = bx + int'($urandom_range(0, 24)); y2 = by + int'($urandom_range(0, 24));
            x3 = bx + int'($urandom_range(0, 24)); y3 = by + int'($urandom_range(0, 24));
            run_tri("rand", x1, y1, x2, y2, x3, y3, $urandom, int'($urandom_range(0, 2)), -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
